paddle_arbiter: RTL and testbench

PADDLE_ARBITER -- requirements
Module: paddle_arbiter

---
 rtl/sbrk_pkg.sv | 54 +++++
 rtl/tick_div.sv | 27 ++
 rtl/paddle_arbiter.sv | 121 ++++++++++++
 tb/tb_paddle_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/sbrk_pkg.sv
// Shared types for the paddle arbiter: Gray phase codes, owner encoding,
// arbiter states, signed direction and the phase-stepping helpers.
package sbrk_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  typedef enum logic {
    OWNER_P1 = 1'b0,
    OWNER_P2 = 1'b1
  } owner_t;

  typedef enum logic {
    ST_OWNED   = 1'b0,
    ST_PENDING = 1'b1
  } arb_state_t;

  typedef logic signed [1:0] dir_t;

  // Both or neither pressed cancel out to zero.
  function automatic dir_t dir_of(input logic left, input logic right);
    dir_t d;
    case ({right, left})
      2'b10:   d = 2'sd1;
      2'b01:   d = -2'sd1;
      default: d = 2'sd0;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] phase_next(input logic [1:0] ph, input dir_t d);
    logic [1:0] nx;
    nx = ph;
    if (d == 2'sd1) begin
      case (ph)
        PH_00:   nx = PH_01;
        PH_01:   nx = PH_11;
        PH_11:   nx = PH_10;
        default: nx = PH_00;
      endcase
    end else if (d == -2'sd1) begin
      case (ph)
        PH_00:   nx = PH_10;
        PH_10:   nx = PH_11;
        PH_11:   nx = PH_01;
        default: nx = PH_00;
      endcase
    end
    return nx;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Free-running divider: tick is high for one clk_sys cycle every CLKDIV cycles,
// first asserted CLKDIV-1 cycles after reset release; no backpressure.
module tick_div #(
  parameter int CLKDIV = 5500
) (
  input  logic clk_sys,
  input  logic Reset_n,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLKDIV - 1);

  logic [15:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/paddle_arbiter.sv
// Merges two players' paddle requests into one quadrature encoder, handing
// ownership over on turn changes; phase moves one cycle after a tick, no backpressure.
module paddle_arbiter
  import sbrk_pkg::*;
#(
  parameter int CLKDIV     = 5500,
  parameter int SW_TIMEOUT = 8
) (
  input  logic clk_sys,
  input  logic Reset_n,
  input  logic left1,
  input  logic right1,
  input  logic left2,
  input  logic right2,
  input  logic turn1,
  input  logic turn2,
  input  logic share,
  output logic enc_a,
  output logic enc_b,
  output logic owner,
  output logic step
);

  localparam logic [7:0] TO_LIMIT = 8'(SW_TIMEOUT);

  logic       tick;
  logic [1:0] phase_q;
  logic [1:0] phase_nx;
  logic       step_q;
  owner_t     owner_q, owner_n, desired;
  arb_state_t state_q, state_n;
  logic [7:0] to_cnt_q, to_cnt_n;
  logic [7:0] to_inc;
  dir_t       dir1, dir2, owner_dir, eff_dir;

  tick_div #(
    .CLKDIV(CLKDIV)
  ) u_tick_div (
    .clk_sys(clk_sys),
    .Reset_n(Reset_n),
    .tick   (tick)
  );

  assign dir1      = dir_of(left1, right1);
  assign dir2      = dir_of(left2, right2);
  assign owner_dir = (owner_q == OWNER_P2) ? dir2 : dir1;
  assign eff_dir   = share ? dir_of(left1 | left2, right1 | right2) : owner_dir;
  // Uses the owner as registered, so a flipping tick still steps with the old owner.
  assign phase_nx  = phase_next(phase_q, eff_dir);
  assign to_inc    = to_cnt_q + 8'd1;

  always_comb begin
    desired = owner_q;
    if (turn2 && !turn1) begin
      desired = OWNER_P2;
    end else if (turn1 && !turn2) begin
      desired = OWNER_P1;
    end
  end

  always_comb begin
    state_n  = state_q;
    owner_n  = owner_q;
    to_cnt_n = to_cnt_q;
    if (share) begin
      state_n  = ST_OWNED;
      to_cnt_n = '0;
    end else begin
      case (state_q)
        ST_OWNED: begin
          if (desired != owner_q) begin
            state_n = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (desired == owner_q) begin
            state_n  = ST_OWNED;
            to_cnt_n = '0;
          end else if (tick) begin
            // Hand over at once when idle, otherwise only after the timeout.
            if (owner_dir == 2'sd0 || to_inc >= TO_LIMIT) begin
              owner_n  = (owner_q == OWNER_P1) ? OWNER_P2 : OWNER_P1;
              state_n  = ST_OWNED;
              to_cnt_n = '0;
            end else begin
              to_cnt_n = to_inc;
            end
          end
        end
        default: begin
          state_n  = ST_OWNED;
          to_cnt_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_OWNED;
      owner_q  <= OWNER_P1;
      to_cnt_q <= '0;
      phase_q  <= PH_00;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      owner_q  <= owner_n;
      to_cnt_q <= to_cnt_n;
      step_q   <= tick && (phase_nx != phase_q);
      if (tick) begin
        phase_q <= phase_nx;
      end
    end
  end

  assign enc_a = phase_q[1];
  assign enc_b = phase_q[0];
  assign owner = owner_q;
  assign step  = step_q;

endmodule

// File: tb/tb_paddle_arbiter.sv
// Directed bench for paddle_arbiter with CLKDIV=4, SW_TIMEOUT=3: a table of
// {inputs, cycles to advance, expected outputs} plus hand-written reset sequences.
module tb_paddle_arbiter;

  logic clk_sys = 1'b0;
  logic Reset_n;
  logic left1, right1, left2, right2, turn1, turn2, share;
  logic enc_a, enc_b, owner, step;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [6:0] in;   // {left1,right1,left2,right2,turn1,turn2,share}
    int         n;
    logic [1:0] enc;
    logic       own;
    logic       stp;
  } vec_t;

  vec_t vq[$];

  paddle_arbiter #(
    .CLKDIV    (4),
    .SW_TIMEOUT(3)
  ) dut (
    .clk_sys(clk_sys),
    .Reset_n(Reset_n),
    .left1  (left1),
    .right1 (right1),
    .left2  (left2),
    .right2 (right2),
    .turn1  (turn1),
    .turn2  (turn2),
    .share  (share),
    .enc_a  (enc_a),
    .enc_b  (enc_b),
    .owner  (owner),
    .step   (step)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic vec_t mk(input logic [6:0] in, input int n, input logic [1:0] e,
                              input logic o, input logic s);
    vec_t v;
    v.in  = in;
    v.n   = n;
    v.enc = e;
    v.own = o;
    v.stp = s;
    return v;
  endfunction

  task automatic drive(input logic [6:0] in);
    {left1, right1, left2, right2, turn1, turn2, share} = in;
  endtask

  task automatic check(input string nm, input logic [1:0] e, input logic o, input logic s);
    n_vec++;
    if ({enc_a, enc_b} !== e || owner !== o || step !== s) begin
      n_bad++;
      $display("FAIL %s: got enc=%b owner=%b step=%b, expected enc=%b owner=%b step=%b",
               nm, {enc_a, enc_b}, owner, step, e, o, s);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask

  initial begin
    // Cycle numbers in comments count clk_sys edges since reset release.
    // P1 forward, four steps (c3..c16)
    vq.push_back(mk(7'b0100000, 3, 2'b00, 1'b0, 1'b0));
    vq.push_back(mk(7'b0100000, 1, 2'b01, 1'b0, 1'b1));
    vq.push_back(mk(7'b0100000, 1, 2'b01, 1'b0, 1'b0));
    vq.push_back(mk(7'b0100000, 3, 2'b11, 1'b0, 1'b1));
    vq.push_back(mk(7'b0100000, 4, 2'b10, 1'b0, 1'b1));
    vq.push_back(mk(7'b0100000, 3, 2'b10, 1'b0, 1'b0));
    vq.push_back(mk(7'b0100000, 1, 2'b00, 1'b0, 1'b1));
    // left1+right1 cancel (c20, c24)
    vq.push_back(mk(7'b1100000, 4, 2'b00, 1'b0, 1'b0));
    vq.push_back(mk(7'b1100000, 4, 2'b00, 1'b0, 1'b0));
    // P1 reverse (c28, c32)
    vq.push_back(mk(7'b1000000, 4, 2'b10, 1'b0, 1'b1));
    vq.push_back(mk(7'b1000000, 4, 2'b11, 1'b0, 1'b1));
    // turn2 while right1 held: timeout flip on 3rd tick (c36..c44)
    vq.push_back(mk(7'b0100010, 4, 2'b10, 1'b0, 1'b1));
    vq.push_back(mk(7'b0100010, 4, 2'b00, 1'b0, 1'b1));
    vq.push_back(mk(7'b0100010, 3, 2'b00, 1'b0, 1'b0));
    vq.push_back(mk(7'b0100010, 1, 2'b01, 1'b1, 1'b1));
    // P2 owns: right1 ignored, right2 steps (c48, c52)
    vq.push_back(mk(7'b0100010, 4, 2'b01, 1'b1, 1'b0));
    vq.push_back(mk(7'b0001010, 4, 2'b11, 1'b1, 1'b1));
    // back to P1 with P2 idle (c56)
    vq.push_back(mk(7'b0000100, 4, 2'b11, 1'b0, 1'b0));
    // turn2 with P1 idle: owner flips at next tick (c59, c60)
    vq.push_back(mk(7'b0000010, 3, 2'b11, 1'b0, 1'b0));
    vq.push_back(mk(7'b0000010, 1, 2'b11, 1'b1, 1'b0));
    vq.push_back(mk(7'b0100010, 4, 2'b11, 1'b1, 1'b0));
    vq.push_back(mk(7'b0001010, 4, 2'b10, 1'b1, 1'b1));
    // pending, then revert clears the timeout; later timeout needs 3 fresh ticks
    vq.push_back(mk(7'b0001100, 4, 2'b00, 1'b1, 1'b1));
    vq.push_back(mk(7'b0001010, 4, 2'b01, 1'b1, 1'b1));
    vq.push_back(mk(7'b0001100, 4, 2'b11, 1'b1, 1'b1));
    vq.push_back(mk(7'b0001100, 4, 2'b10, 1'b1, 1'b1));
    vq.push_back(mk(7'b0001100, 4, 2'b00, 1'b0, 1'b1));
    // share mode: right1 vs left2 cancel, then right1 alone; owner ignores turn2
    vq.push_back(mk(7'b0110011, 4, 2'b00, 1'b0, 1'b0));
    vq.push_back(mk(7'b0100011, 4, 2'b01, 1'b0, 1'b1));
    vq.push_back(mk(7'b0100011, 4, 2'b11, 1'b0, 1'b1));
    // leave share with turn2: enters PENDING at phase 11 (c102)
    vq.push_back(mk(7'b0000010, 2, 2'b11, 1'b0, 1'b0));

    drive(7'b0000000);
    Reset_n = 1'b0;
    cycles(3);
    check("reset_hold", 2'b00, 1'b0, 1'b0);
    @(posedge clk_sys);
    #2;
    Reset_n = 1'b1;
    check("reset_release", 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].in);
      cycles(vq[i].n);
      check($sformatf("vec%0d", i), vq[i].enc, vq[i].own, vq[i].stp);
    end

    // Reset mid-PENDING with phase 11: outputs drop at once, switch abandoned.
    Reset_n = 1'b0;
    #1;
    check("async_reset", 2'b00, 1'b0, 1'b0);
    @(posedge clk_sys);
    #2;
    Reset_n = 1'b1;
    drive(7'b0100000);
    cycles(3);
    check("post_reset_c3", 2'b00, 1'b0, 1'b0);
    cycles(1);
    check("post_reset_c4", 2'b01, 1'b0, 1'b1);
    cycles(1);
    check("post_reset_c5", 2'b01, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
